// File: rtl/ads_serial_capture.sv
// Serial capture engine for daisy-chained ADS1672-class converters.
// Drives sclk/fsx/start and deserialises NUM_CH words per frame.
`timescale 1ns/1ps
module ads_serial_capture #(
  parameter int DATA_WIDTH  = 24,
  parameter int NUM_CH      = 1,
  parameter int SCLK_DIV    = 2,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic measure,
  input  logic continuous,
  input  logic drdy_n,
  input  logic drr,
  output logic sclk,
  output logic fsx,
  output logic start,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] data_ch,
  output logic data_valid,
  output logic busy,
  output logic overrun,
  output logic timeout
);

  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int DVW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int TCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [CHW-1:0] CH_LAST  = CHW'(NUM_CH - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);
  localparam logic [DVW-1:0] DIV_LAST = DVW'(SCLK_DIV - 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FRAME,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic sync1_q, sync2_q, sync3_q;
  logic [DVW-1:0] div_q, div_d;
  logic sclk_q, sclk_d;
  logic [BCW-1:0] bit_q, bit_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic [DATA_WIDTH-2:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [CHW-1:0] data_ch_q, data_ch_d;
  logic valid_q, valid_d;
  logic overrun_q, overrun_d;
  logic timeout_q, timeout_d;

  logic drdy_fall;
  logic in_ser;
  logic div_last;
  logic sclk_rise;
  logic [DATA_WIDTH-1:0] word;

  assign drdy_fall = sync3_q & ~sync2_q;
  assign in_ser    = (state_q == S_FRAME) ||
                     (state_q == S_SHIFT);
  assign div_last  = (div_q == DIV_LAST);
  assign sclk_rise = in_ser & ~sclk_q & div_last;
  assign word      = {shreg_q, drr};

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    sclk_d     = sclk_q;
    bit_d      = bit_q;
    ch_d       = ch_q;
    tmo_d      = tmo_q;
    shreg_d    = shreg_q;
    data_out_d = data_out_q;
    data_ch_d  = data_ch_q;
    valid_d    = 1'b0;
    overrun_d  = overrun_q;
    timeout_d  = timeout_q;

    if (in_ser) begin
      if (div_last) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (measure) begin
          state_d   = S_ARM;
          tmo_d     = '0;
          timeout_d = 1'b0;
          overrun_d = 1'b0;
        end
      end
      S_ARM: begin
        // a data-ready edge beats a simultaneous expiry
        if (drdy_fall) begin
          state_d = S_FRAME;
          div_d   = '0;
          sclk_d  = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_FRAME: begin
        if (drdy_fall) overrun_d = 1'b1;
        if (sclk_q && div_last) begin
          state_d = S_SHIFT;
          bit_d   = '0;
          ch_d    = '0;
        end
      end
      S_SHIFT: begin
        if (drdy_fall) overrun_d = 1'b1;
        if (sclk_rise) begin
          shreg_d = word[DATA_WIDTH-2:0];
          if (bit_q == BIT_LAST) begin
            bit_d      = '0;
            data_out_d = word;
            data_ch_d  = ch_q;
            valid_d    = 1'b1;
            if (ch_q == CH_LAST) begin
              state_d = S_DONE;
              sclk_d  = 1'b0;
              div_d   = '0;
            end else begin
              ch_d = ch_q + 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (continuous) begin
          state_d = S_ARM;
          tmo_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      sync3_q    <= 1'b1;
      div_q      <= '0;
      sclk_q     <= 1'b0;
      bit_q      <= '0;
      ch_q       <= '0;
      tmo_q      <= '0;
      shreg_q    <= '0;
      data_out_q <= '0;
      data_ch_q  <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= drdy_n;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      bit_q      <= bit_d;
      ch_q       <= ch_d;
      tmo_q      <= tmo_d;
      shreg_q    <= shreg_d;
      data_out_q <= data_out_d;
      data_ch_q  <= data_ch_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign start      = busy;
  assign sclk       = sclk_q;
  assign fsx        = (state_q == S_FRAME);
  assign data_out   = data_out_q;
  assign data_ch    = data_ch_q;
  assign data_valid = valid_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

endmodule
